pipe_stage_elastic: RTL

Parametrised elastic pipeline stage register. It is the successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic data payload and a control payload across one stage boundary.
- Uses a valid/ready handshake and a one-entry skid buffer, so a backpressure stall does not need a combinational ready path through the stage.
- Provides a synchronous flush for branch mispredict and jump recovery. Flushed or empty slots present a NOP, with all control bits zero.

---
 rtl/pipe_stage_elastic.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic -- elastic pipeline stage register with one-entry skid.
//
// Carries a data payload and a control payload across one stage boundary
// with a valid/ready handshake. A skid entry absorbs the one entry already
// in flight when downstream stalls. This keeps in_ready purely registered:
// it is ~skid_valid and has no path from out_ready.
//
// Bubble rule: any slot whose valid bit is cleared also has its ctrl
// register written to zero, so out_ctrl reads as a NOP whenever out_valid=0.
// Data registers are never cleared on a bubble and keep their last value.
//
// flush kills both held entries and discards the input presented in the
// same cycle. A downstream handshake in the flush cycle is still treated as
// consumed. rst_n (async, active low) overrides flush.
//
// Optional build macro: PIPE_STALL_CNT_EN adds a saturating stall_cnt
// output. It counts cycles with out_valid=1 and out_ready=0, and only
// rst_n clears it.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 synchronous kill of all held entries
//   in_valid/in_ready     upstream handshake (in_ready registered)
//   in_data/in_ctrl       upstream payload
//   out_valid/out_ready   downstream handshake
//   out_data/out_ctrl     held payload (out_ctrl = 0 when out_valid = 0)
//   stall_cnt             stall cycle count (PIPE_STALL_CNT_EN only)
module pipe_stage_elastic #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  // Main slot may change when it is empty or its entry is leaving.
  logic main_adv;
  assign main_adv = ~main_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
    end else if (main_adv) begin
      if (skid_valid) begin
        // FULL draining: the older skid entry moves up; in_ready was 0.
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_ctrl  <= skid_ctrl;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
      end else if (in_valid) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
        main_ctrl  <= in_ctrl;
      end else begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
      end
    end else if (in_valid && !skid_valid) begin
      // Main stalled: park the incoming entry behind it.
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_ctrl  <= in_ctrl;
    end
  end

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;

`ifdef PIPE_STALL_CNT_EN
  // Saturating count of stalled output cycles; flush deliberately ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (main_valid && !out_ready && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end
`else
  // No counter in this build; CNT_W is kept only for a uniform interface.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
